// File: rtl/tree_noc_pkg.sv
// Shared definitions for the tree NoC merge/copy nodes.
// Flit layout, widths and output-stage state encoding.
package tree_noc_pkg;

    localparam int WIDTH_packet = 28;
    localparam int WIDTH_addr   = 3;
    localparam int WIDTH_dest   = 3;
    localparam int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest;
    localparam int DEPTH        = 2;

    typedef struct packed {
        logic [WIDTH_dest-1:0]   dest;
        logic [WIDTH_addr-1:0]   addr;
        logic [WIDTH_packet-1:0] packet;
    } flit_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Round-robin pick: prefer rr if that side has data, else the other.
    function automatic logic rr_pick(
        input logic rr,
        input logic ne0,
        input logic ne1
    );
        logic pref_ne;
        pref_ne = rr ? ne1 : ne0;
        return pref_ne ? rr : ~rr;
    endfunction

endpackage

// File: rtl/merge_fifo.sv
// Two-entry input FIFO for one child link of the merge node.
// Not-full is a flop, so the upstream ready never sees same-cycle pops.
module merge_fifo #(
    parameter int WIDTH = tree_noc_pkg::WIDTH,
    parameter int DEPTH = tree_noc_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             not_full
);
    import tree_noc_pkg::*;

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             nfull_q, nfull_d;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: a full FIFO refuses writes even when popped.
    always_comb begin
        do_push = push && nfull_q;
        do_pop  = pop && (count_q != 2'd0);
    end

    // Storage, pointer and occupancy updates.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        nfull_d = (count_d != FULL_CNT);
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            nfull_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            nfull_q  <= nfull_d;
        end
    end

    // Expose head and status straight from the registers.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        count    = count_q;
        not_full = nfull_q;
    end

endmodule

// File: rtl/merge_tree.sv
// Two-input merge node: two child FIFOs, round-robin arbiter and
// a single registered output stage toward the parent link.
module merge_tree #(
    parameter int WIDTH_packet = tree_noc_pkg::WIDTH_packet,
    parameter int WIDTH_addr   = tree_noc_pkg::WIDTH_addr,
    parameter int WIDTH_dest   = tree_noc_pkg::WIDTH_dest,
    parameter int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
    parameter int DEPTH        = tree_noc_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src
);
    import tree_noc_pkg::*;

    logic [WIDTH-1:0] head0, head1;
    logic [1:0]       cnt0, cnt1;
    logic             nf0, nf1;
    logic             ne0, ne1;
    logic             push0, push1;
    logic             pop0, pop1;
    logic             free;
    logic             grant;
    logic             gnt_idx;

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             rr_q, rr_d;

    merge_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push_data (in0_data),
        .push      (push0),
        .pop       (pop0),
        .head      (head0),
        .count     (cnt0),
        .not_full  (nf0)
    );

    merge_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push_data (in1_data),
        .push      (push1),
        .pop       (pop1),
        .head      (head1),
        .count     (cnt1),
        .not_full  (nf1)
    );

    // Input side: a write happens on valid && ready.
    always_comb begin
        push0 = in0_valid && in0_ready;
        push1 = in1_valid && in1_ready;
        ne0   = (cnt0 != 2'd0);
        ne1   = (cnt1 != 2'd0);
    end

    // Arbiter: grant one non-empty FIFO whenever the output stage frees up.
    always_comb begin
        free    = (state_q == OUT_EMPTY) || out_ready;
        grant   = free && (ne0 || ne1);
        gnt_idx = rr_pick(rr_q, ne0, ne1);
        pop0    = grant && !gnt_idx;
        pop1    = grant && gnt_idx;
    end

    // Output-stage next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: begin
                if (grant) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready && !grant) begin
                    state_d = OUT_EMPTY;
                end
            end
        endcase
    end

    // Output register and round-robin pointer load on a grant.
    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        rr_d   = rr_q;
        if (grant) begin
            data_d = gnt_idx ? head1 : head0;
            src_d  = gnt_idx;
            rr_d   = ~gnt_idx;
        end
    end

    // State register; reset drops any pending output flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output data, source and arbiter pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            src_q  <= 1'b0;
            rr_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            src_q  <= src_d;
            rr_q   <= rr_d;
        end
    end

    // Outputs come from registers; ready is masked while in reset.
    always_comb begin
        out_valid = (state_q == OUT_FULL);
        out_data  = data_q;
        out_src   = src_q;
        in0_ready = nf0 && !rst;
        in1_ready = nf1 && !rst;
    end

endmodule
